// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main controller: state names,
// opcodes, ALU operation and datapath mux select codes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_B     = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Moore control word; pcwrite and branch are combined into pcen outside the decode.
    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic       pcwrite;
        logic       branch;
        logic       instrDone;
        logic       illegalOp;
    } ctrl_t;

    function automatic logic isLegalOp(input logic [5:0] op, input logic supportBne);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: return 1'b1;
            OP_BNE:                                        return supportBne;
            default:                                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_maindec_fsm_if.sv
// Controller <-> datapath bundle: opcode and zero flag in, mux selects and enables out.
interface mips_maindec_fsm_if;

    logic [5:0] op;
    logic       zero;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       pcen;
    logic       instr_done;
    logic       illegal_op;
    logic [3:0] state_o;

    // The controller side drives every control; the datapath side supplies op and zero.
    modport master (
        input  op, zero,
        output iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
               alusrcb, pcsrc, aluop, pcen, instr_done, illegal_op, state_o
    );

    modport slave (
        output op, zero,
        input  iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
               alusrcb, pcsrc, aluop, pcen, instr_done, illegal_op, state_o
    );

endinterface

// File: rtl/mips_maindec_fsm.sv
// Multicycle MIPS main decoder: Moore FSM stepping each instruction through
// fetch, decode, execute, memory and writeback, plus the qualified PC enable.
module mips_maindec_fsm
    import mips_ctrl_pkg::*;
#(
    parameter bit SUPPORT_BNE = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    mips_maindec_fsm_if.master    bus
);

    state_e r_state;
    state_e w_nextState;
    logic   r_isBne;
    ctrl_t  w_ctl;

    // is_bne is latched in DECODE so BRANCH knows which sense of zero to test.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_isBne <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (r_state == S_DECODE) begin
                r_isBne <= SUPPORT_BNE && (bus.op == OP_BNE);
            end
        end
    end

    always_comb begin
        w_nextState = S_FETCH;
        case (r_state)
            S_FETCH: w_nextState = S_DECODE;
            S_DECODE: begin
                if (isLegalOp(bus.op, SUPPORT_BNE)) begin
                    case (bus.op)
                        OP_LW, OP_SW:   w_nextState = S_MEMADR;
                        OP_RTYPE:       w_nextState = S_EXECUTE;
                        OP_BEQ, OP_BNE: w_nextState = S_BRANCH;
                        OP_ADDI:        w_nextState = S_ADDIEXEC;
                        OP_J:           w_nextState = S_JUMP;
                        default:        w_nextState = S_FETCH;
                    endcase
                end
            end
            S_MEMADR:   w_nextState = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:    w_nextState = S_MEMWB;
            S_MEMWB:    w_nextState = S_FETCH;
            S_MEMWR:    w_nextState = S_FETCH;
            S_EXECUTE:  w_nextState = S_ALUWB;
            S_ALUWB:    w_nextState = S_FETCH;
            S_BRANCH:   w_nextState = S_FETCH;
            S_ADDIEXEC: w_nextState = S_ADDIWB;
            S_ADDIWB:   w_nextState = S_FETCH;
            S_JUMP:     w_nextState = S_FETCH;
            default:    w_nextState = S_FETCH;
        endcase
    end

    always_comb begin
        w_ctl = '0;
        case (r_state)
            S_FETCH: begin
                w_ctl.irwrite = 1'b1;
                w_ctl.alusrcb = ALUSRCB_FOUR;
                w_ctl.aluop   = ALUOP_ADD;
                w_ctl.pcsrc   = PCSRC_ALU;
                w_ctl.pcwrite = 1'b1;
            end
            S_DECODE: begin
                w_ctl.alusrcb   = ALUSRCB_IMMSH;
                w_ctl.aluop     = ALUOP_ADD;
                w_ctl.illegalOp = !isLegalOp(bus.op, SUPPORT_BNE);
            end
            S_MEMADR: begin
                w_ctl.alusrca = 1'b1;
                w_ctl.alusrcb = ALUSRCB_IMM;
                w_ctl.aluop   = ALUOP_ADD;
            end
            S_MEMRD: begin
                w_ctl.iord = 1'b1;
            end
            S_MEMWB: begin
                w_ctl.memtoreg  = 1'b1;
                w_ctl.regwrite  = 1'b1;
                w_ctl.instrDone = 1'b1;
            end
            S_MEMWR: begin
                w_ctl.iord      = 1'b1;
                w_ctl.memwrite  = 1'b1;
                w_ctl.instrDone = 1'b1;
            end
            S_EXECUTE: begin
                w_ctl.alusrca = 1'b1;
                w_ctl.alusrcb = ALUSRCB_B;
                w_ctl.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                w_ctl.regdst    = 1'b1;
                w_ctl.regwrite  = 1'b1;
                w_ctl.instrDone = 1'b1;
            end
            S_BRANCH: begin
                w_ctl.alusrca   = 1'b1;
                w_ctl.alusrcb   = ALUSRCB_B;
                w_ctl.aluop     = ALUOP_SUB;
                w_ctl.pcsrc     = PCSRC_ALUOUT;
                w_ctl.branch    = 1'b1;
                w_ctl.instrDone = 1'b1;
            end
            S_ADDIEXEC: begin
                w_ctl.alusrca = 1'b1;
                w_ctl.alusrcb = ALUSRCB_IMM;
                w_ctl.aluop   = ALUOP_ADD;
            end
            S_ADDIWB: begin
                w_ctl.regwrite  = 1'b1;
                w_ctl.instrDone = 1'b1;
            end
            S_JUMP: begin
                w_ctl.pcsrc     = PCSRC_JUMP;
                w_ctl.pcwrite   = 1'b1;
                w_ctl.instrDone = 1'b1;
            end
            default: w_ctl = '0;
        endcase

        // Reset aborts the instruction: no write fires, selects park on their FETCH values.
        if (reset) begin
            w_ctl         = '0;
            w_ctl.alusrcb = ALUSRCB_FOUR;
        end
    end

    assign bus.iord       = w_ctl.iord;
    assign bus.memwrite   = w_ctl.memwrite;
    assign bus.irwrite    = w_ctl.irwrite;
    assign bus.regdst     = w_ctl.regdst;
    assign bus.memtoreg   = w_ctl.memtoreg;
    assign bus.regwrite   = w_ctl.regwrite;
    assign bus.alusrca    = w_ctl.alusrca;
    assign bus.alusrcb    = w_ctl.alusrcb;
    assign bus.pcsrc      = w_ctl.pcsrc;
    assign bus.aluop      = w_ctl.aluop;
    assign bus.instr_done = w_ctl.instrDone;
    assign bus.illegal_op = w_ctl.illegalOp;
    assign bus.state_o    = r_state;
    assign bus.pcen       = w_ctl.pcwrite | (w_ctl.branch & (bus.zero ^ r_isBne));

endmodule

// File: tb/tb_mips_maindec_fsm.sv
// Bench for mips_maindec_fsm: an instruction-step reference model checked every
// cycle, plus directed per-instruction traces with literal expectations.
module tb_mips_maindec_fsm;
    import mips_ctrl_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic       pcen;
        logic       done;
        logic       illegal;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;

    mips_maindec_fsm_if bus();

    mips_maindec_fsm #(.SUPPORT_BNE(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h want=0x%0h", name, got, want);
        end
    endtask

    // Cycles from FETCH through the final state of each instruction class.
    function automatic int latencyOf(input logic [5:0] opv);
        case (opv)
            OP_LW:                 return 5;
            OP_SW, OP_RTYPE, OP_ADDI: return 4;
            OP_BEQ, OP_BNE, OP_J:  return 3;
            default:               return 2;
        endcase
    endfunction

    // What the controller must show on step 'step' of an instruction with opcode opv.
    function automatic obs_t expectCtl(input int step, input logic [5:0] opv, input logic rst, input logic z);
        obs_t c;
        c = '0;
        if (step == 0) begin
            c.st = 4'd0; c.irwrite = 1'b1; c.alusrcb = 2'b01; c.pcen = 1'b1;
        end else if (step == 1) begin
            c.st = 4'd1; c.alusrcb = 2'b11;
            c.illegal = (latencyOf(opv) == 2);
        end else begin
            case (opv)
                OP_LW: begin
                    if (step == 2) begin c.st = 4'd2; c.alusrca = 1'b1; c.alusrcb = 2'b10; end
                    else if (step == 3) begin c.st = 4'd3; c.iord = 1'b1; end
                    else begin c.st = 4'd4; c.memtoreg = 1'b1; c.regwrite = 1'b1; c.done = 1'b1; end
                end
                OP_SW: begin
                    if (step == 2) begin c.st = 4'd2; c.alusrca = 1'b1; c.alusrcb = 2'b10; end
                    else begin c.st = 4'd5; c.iord = 1'b1; c.memwrite = 1'b1; c.done = 1'b1; end
                end
                OP_RTYPE: begin
                    if (step == 2) begin c.st = 4'd6; c.alusrca = 1'b1; c.aluop = 2'b10; end
                    else begin c.st = 4'd7; c.regdst = 1'b1; c.regwrite = 1'b1; c.done = 1'b1; end
                end
                OP_ADDI: begin
                    if (step == 2) begin c.st = 4'd9; c.alusrca = 1'b1; c.alusrcb = 2'b10; end
                    else begin c.st = 4'd10; c.regwrite = 1'b1; c.done = 1'b1; end
                end
                OP_BEQ, OP_BNE: begin
                    c.st = 4'd8; c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.done = 1'b1;
                    c.pcen = z ^ (opv == OP_BNE);
                end
                OP_J: begin
                    c.st = 4'd11; c.pcsrc = 2'b10; c.pcen = 1'b1; c.done = 1'b1;
                end
                default: c = '0;
            endcase
        end
        if (rst) begin
            c.iord = 0; c.memwrite = 0; c.irwrite = 0; c.regdst = 0; c.memtoreg = 0;
            c.regwrite = 0; c.alusrca = 0; c.alusrcb = 2'b01; c.pcsrc = 0; c.aluop = 0;
            c.pcen = 0; c.done = 0; c.illegal = 0;
        end
        return c;
    endfunction

    int         mStep = 0;
    logic [5:0] mOp = 6'h3f;
    logic       mValid = 1'b0;

    // Model advances one step per clock; the opcode is fixed once decode has seen it.
    always @(posedge clk) begin
        if (reset) begin
            mStep  = 0;
            mValid = 1'b1;
        end else if (mValid) begin
            if (mStep == 1) mOp = bus.op;
            mStep++;
            if (mStep >= latencyOf(mOp)) mStep = 0;
        end
    end

    always @(negedge clk) begin
        obs_t expv;
        obs_t act;
        if (mValid) begin
            expv = expectCtl(mStep, (mStep == 1) ? bus.op : mOp, reset, bus.zero);
            act.st = bus.state_o;   act.iord = bus.iord;         act.memwrite = bus.memwrite;
            act.irwrite = bus.irwrite; act.regdst = bus.regdst;  act.memtoreg = bus.memtoreg;
            act.regwrite = bus.regwrite; act.alusrca = bus.alusrca; act.alusrcb = bus.alusrcb;
            act.pcsrc = bus.pcsrc;  act.aluop = bus.aluop;       act.pcen = bus.pcen;
            act.done = bus.instr_done; act.illegal = bus.illegal_op;
            checkOutput("cycle model", 32'(act), 32'(expv));
        end
    end

    logic [3:0] trState [0:7];
    logic [1:0] trAluop [0:7];
    logic [1:0] trPcsrc [0:7];
    logic [7:0] trRegwrite, trMemwrite, trPcen, trDone, trIllegal, trIord, trRegdst, trMemtoreg;

    // Runs one instruction for n cycles, recording a per-cycle trace (bit i = cycle i).
    task automatic applyStimulus(input logic [5:0] opv, input logic z, input int n);
        bus.op   = opv;
        bus.zero = z;
        trRegwrite = '0; trMemwrite = '0; trPcen = '0; trDone = '0;
        trIllegal = '0; trIord = '0; trRegdst = '0; trMemtoreg = '0;
        for (int i = 0; i < n; i++) begin
            trState[i] = bus.state_o;  trAluop[i] = bus.aluop;  trPcsrc[i] = bus.pcsrc;
            trRegwrite[i] = bus.regwrite; trMemwrite[i] = bus.memwrite; trPcen[i] = bus.pcen;
            trDone[i] = bus.instr_done; trIllegal[i] = bus.illegal_op; trIord[i] = bus.iord;
            trRegdst[i] = bus.regdst; trMemtoreg[i] = bus.memtoreg;
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] packStates(input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r = (r << 4) | 32'(trState[i]);
        return r;
    endfunction

    initial begin
        reset    = 1'b1;
        bus.op   = OP_RTYPE;
        bus.zero = 1'b0;
        @(posedge clk); #1;
        checkOutput("reset state", 32'(bus.state_o), 32'd0);
        checkOutput("reset irwrite", 32'(bus.irwrite), 32'd0);
        checkOutput("reset pcen", 32'(bus.pcen), 32'd0);
        checkOutput("reset alusrcb", 32'(bus.alusrcb), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;

        applyStimulus(OP_LW, 1'b0, 5);
        checkOutput("lw states", packStates(5), 32'h01234);
        checkOutput("lw aluop add", {26'd0, trAluop[0], trAluop[1], trAluop[2]}, 32'd0);
        checkOutput("lw regwrite", 32'(trRegwrite[4:0]), 32'b10000);
        checkOutput("lw memtoreg", 32'(trMemtoreg[4:0]), 32'b10000);
        checkOutput("lw done", 32'(trDone[4:0]), 32'b10000);
        checkOutput("lw back fetch", 32'(bus.state_o), 32'd0);

        applyStimulus(OP_RTYPE, 1'b0, 4);
        checkOutput("r states", packStates(4), 32'h0167);
        checkOutput("r aluop", {24'd0, trAluop[0], trAluop[1], trAluop[2], trAluop[3]}, 32'b00_00_10_00);
        checkOutput("r regwrite", 32'(trRegwrite[3:0]), 32'b1000);
        checkOutput("r regdst", 32'(trRegdst[3:0]), 32'b1000);

        applyStimulus(OP_BEQ, 1'b1, 3);
        checkOutput("beq taken states", packStates(3), 32'h018);
        checkOutput("beq taken pcen", 32'(trPcen[2:0]), 32'b101);
        checkOutput("beq pcsrc", 32'(trPcsrc[2]), 32'd1);
        checkOutput("beq aluop", 32'(trAluop[2]), 32'd1);
        applyStimulus(OP_BEQ, 1'b0, 3);
        checkOutput("beq not taken pcen", 32'(trPcen[2:0]), 32'b001);
        applyStimulus(OP_BNE, 1'b0, 3);
        checkOutput("bne taken pcen", 32'(trPcen[2:0]), 32'b101);
        applyStimulus(OP_BNE, 1'b1, 3);
        checkOutput("bne not taken pcen", 32'(trPcen[2:0]), 32'b001);

        applyStimulus(OP_SW, 1'b0, 4);
        checkOutput("sw states", packStates(4), 32'h0125);
        checkOutput("sw memwrite", 32'(trMemwrite[3:0]), 32'b1000);
        checkOutput("sw iord", 32'(trIord[3:0]), 32'b1000);
        checkOutput("sw regwrite", 32'(trRegwrite[3:0]), 32'd0);

        applyStimulus(OP_J, 1'b0, 3);
        checkOutput("j states", packStates(3), 32'h01B);
        checkOutput("j pcsrc", 32'(trPcsrc[2]), 32'd2);
        checkOutput("j pcen", 32'(trPcen[2:0]), 32'b101);

        applyStimulus(OP_ADDI, 1'b0, 4);
        checkOutput("addi states", packStates(4), 32'h019A);
        checkOutput("addi regwrite", 32'(trRegwrite[3:0]), 32'b1000);

        applyStimulus(6'b111111, 1'b1, 2);
        checkOutput("illegal states", packStates(2), 32'h01);
        checkOutput("illegal flag", 32'(trIllegal[1:0]), 32'b10);
        checkOutput("illegal writes", {30'd0, trRegwrite[1] | trMemwrite[1], trPcen[1]}, 32'd0);
        checkOutput("illegal back fetch", 32'(bus.state_o), 32'd0);

        applyStimulus(OP_LW, 1'b0, 3);
        reset = 1'b1;
        #1;
        checkOutput("abort in memrd", 32'(bus.state_o), 32'd3);
        checkOutput("abort irwrite/pcen/regwrite", {29'd0, bus.irwrite, bus.pcen, bus.regwrite}, 32'd0);
        @(posedge clk); #1;
        checkOutput("abort to fetch", 32'(bus.state_o), 32'd0);
        checkOutput("abort fetch irwrite/pcen", {30'd0, bus.irwrite, bus.pcen}, 32'd0);
        reset = 1'b0;
        applyStimulus(OP_LW, 1'b0, 5);
        checkOutput("lw after abort", packStates(5), 32'h01234);
        checkOutput("lw after abort regwrite", 32'(trRegwrite[4:0]), 32'b10000);

        @(posedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_maindec_fsm.md
Name: mips_maindec_fsm

Overview:
Multicycle MIPS main control unit: a Moore FSM that sequences each instruction through fetch, decode, execute, memory and writeback.
- Sits directly upstream of the ALU decoder and drives its 2-bit aluop input; aludec turns aluop plus funct into alucontrol.
- Also drives all datapath mux selects and write enables, and produces the qualified PC enable.

Parameters:
SUPPORT_BNE, 1, when 1 decode bne (op 000101) into the branch state with an inverted zero test; when 0, bne is an illegal opcode.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
op  input  6  opcode field from the instruction register; sampled only in DECODE.
zero  input  1  ALU zero flag; used only in BRANCH.
iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
memwrite  output  1  data memory write enable.
irwrite  output  1  instruction register write enable.
regdst  output  1  register destination select: 1 = rd, 0 = rt.
memtoreg  output  1  register write data select: 1 = memory data, 0 = ALUOut.
regwrite  output  1  register file write enable.
alusrca  output  1  ALU A select: 0 = PC, 1 = register A.
alusrcb  output  2  ALU B select: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
pcsrc  output  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
aluop  output  2  to aludec: 00 = add, 01 = sub, 10 = decode by funct.
pcen  output  1  PC enable: pcwrite OR (branch AND (zero XOR is_bne)).
instr_done  output  1  one-cycle pulse in the final state of each instruction.
illegal_op  output  1  one-cycle pulse in DECODE when op is unsupported.
state_o  output  4  current state encoding, for debug and verification.

Behaviour:
- Clock and reset: one clock. reset is synchronous, active-high; ports are named clk and reset.
- Reset action: when reset is high at a rising edge, state becomes FETCH and the is_bne register clears.
- Outputs during reset:
  - While reset is high, force to 0: irwrite, pcen, memwrite, regwrite, instr_done, illegal_op.
  - Mux selects show FETCH values: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, regdst=0, memtoreg=0.
- Reset asserted mid-instruction aborts that instruction; no write enable is asserted in the reset cycle.
- Output style: Moore outputs, decoded combinationally from the state register only. pcen is the single exception: it also uses zero and the registered is_bne.
- Default for any output not listed in a state: 0 (alusrcb 00, pcsrc 00, aluop 00).
- States, transitions and outputs (4-bit encoding in listed order, 0..11):
  - FETCH: iord=0, irwrite=1, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, pcwrite=1. Next: DECODE.
  - DECODE: alusrca=0, alusrcb=11, aluop=00. Captures is_bne <= (op==000101).
    - Next by op: lw 100011 / sw 101011 -> MEMADR; R-type 000000 -> EXECUTE; beq 000100 / bne -> BRANCH; addi 001000 -> ADDIEXEC; j 000010 -> JUMP.
    - Any other op: illegal_op=1, next FETCH.
  - MEMADR: alusrca=1, alusrcb=10, aluop=00. Next: MEMRD if lw, MEMWR if sw (op is still held by the IR).
  - MEMRD: iord=1. Next: MEMWB.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1, instr_done=1. Next: FETCH.
  - MEMWR: iord=1, memwrite=1, instr_done=1. Next: FETCH.
  - EXECUTE: alusrca=1, alusrcb=00, aluop=10. Next: ALUWB.
  - ALUWB: regdst=1, memtoreg=0, regwrite=1, instr_done=1. Next: FETCH.
  - BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1, instr_done=1. Next: FETCH.
  - ADDIEXEC: alusrca=1, alusrcb=10, aluop=00. Next: ADDIWB.
  - ADDIWB: regdst=0, memtoreg=0, regwrite=1, instr_done=1. Next: FETCH.
  - JUMP: pcsrc=10, pcwrite=1, instr_done=1. Next: FETCH.
- Unused encodings 12..15: next state FETCH; all enables 0.
- Instruction latency in cycles, FETCH through done: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3, illegal 2.
- zero is ignored outside BRANCH.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state enum typedef (4-bit) and opcode localparams: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J;
  - aluop localparams: ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10;
  - alusrcb and pcsrc encodings.
- No sub-module. Next-state logic and output decode are two always blocks plus one state register, in a single module.

Test Plan:
- reset=1 for 2 cycles, then op=100011 (lw): state_o goes 0,1,2,3,4,0. aluop is 00 in FETCH, DECODE and MEMADR. regwrite=1 and memtoreg=1 only in cycle 5; instr_done pulses in cycle 5.
- op=000000 (R-type): aluop=10 exactly in EXECUTE; regwrite=1 with regdst=1 in ALUWB; 4 cycles total.
- op=000100 with zero=1: pcen=1 in BRANCH with pcsrc=01 and aluop=01. Repeat with zero=0: pcen=0. op=000101 with zero=0: pcen=1.
- op=101011 (sw): memwrite=1 with iord=1 for exactly one cycle; regwrite never asserted. op=000010 (j): pcsrc=10 and pcen=1 in cycle 3.
- op=111111: illegal_op=1 in DECODE, then FETCH; no regwrite, memwrite or pcen beyond FETCH.
- Assert reset during MEMRD of lw: the next state is FETCH; regwrite stays 0; irwrite and pcen are 0 while reset is high.
